// File: rtl/lsu_pkg.sv
// Shared load/store op encodings, FSM state type and alignment helpers for the MEM-stage LSU.
package lsu_pkg;

    typedef enum logic [3:0] {
        OP_LW  = 4'b0000,
        OP_LH  = 4'b0001,
        OP_LHU = 4'b0010,
        OP_LB  = 4'b0011,
        OP_LBU = 4'b0100,
        OP_SW  = 4'b1000,
        OP_SH  = 4'b1001,
        OP_SB  = 4'b1010
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RESP
    } lsu_state_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU,
            OP_SW, OP_SH, OP_SB: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] addr);
        case (op)
            OP_LW, OP_SW:          return addr != 2'b00;
            OP_LH, OP_LHU, OP_SH:  return addr[0];
            default:               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Big-endian byte-lane logic: load extraction/extension and sub-word store merge.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = '0;
        case (addr)
            2'd0: byte_sel = old_word[31:24];
            2'd1: byte_sel = old_word[23:16];
            2'd2: byte_sel = old_word[15:8];
            2'd3: byte_sel = old_word[7:0];
            default: byte_sel = '0;
        endcase
        half_sel = addr[1] ? old_word[15:0] : old_word[31:16];

        load_data = '0;
        case (op)
            OP_LW:   load_data = old_word;
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'h0000, half_sel};
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'h000000, byte_sel};
            default: load_data = '0;
        endcase

        // Untouched lanes keep the word just read back from memory.
        store_word = old_word;
        case (op)
            OP_SW: store_word = wdata;
            OP_SH: begin
                if (addr[1]) store_word[15:0]  = wdata[15:0];
                else         store_word[31:16] = wdata[15:0];
            end
            OP_SB: begin
                case (addr)
                    2'd0: store_word[31:24] = wdata[7:0];
                    2'd1: store_word[23:16] = wdata[7:0];
                    2'd2: store_word[15:8]  = wdata[7:0];
                    2'd3: store_word[7:0]   = wdata[7:0];
                    default: store_word = old_word;
                endcase
            end
            default: store_word = old_word;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: ready/valid toward the pipeline, registered word-wide memory master.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [3:0]    req_op,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-3:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack
);

    lsu_state_e  state, state_next;
    logic [3:0]  op_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] wdata_q;
    logic        accept;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign req_ready = (state == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign req_err   = !op_is_legal(req_op) || op_misaligned(req_op, req_addr[1:0]);

    lsu_lane u_lane (
        .op         (op_q),
        .addr       (addr_lo_q),
        .old_word   (mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err)                        state_next = ST_RESP;
                    else if (req_op == OP_SW)           state_next = ST_WR;
                    else                                state_next = ST_RD;
                end
            end
            ST_RD: begin
                // sh/sb read the old word first, then write the merged word.
                if (mem_ack) state_next = op_is_store(op_q) ? ST_WR : ST_RESP;
            end
            ST_WR:   if (mem_ack) state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_q       <= '0;
            addr_lo_q  <= '0;
            wdata_q    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_next;
            mem_req    <= (state_next == ST_RD) || (state_next == ST_WR);
            mem_we     <= (state_next == ST_WR);
            resp_valid <= (state_next == ST_RESP);

            if (accept) begin
                op_q      <= req_op;
                addr_lo_q <= req_addr[1:0];
                wdata_q   <= req_wdata;
                mem_addr  <= req_addr[AW-1:2];
                mem_wdata <= req_wdata;
                if (req_err) begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b1;
                end
            end

            if (state == ST_RD && mem_ack) begin
                if (op_is_store(op_q)) begin
                    mem_wdata <= store_word;
                end else begin
                    resp_rdata <= load_data;
                    resp_err   <= 1'b0;
                end
            end

            if (state == ST_WR && mem_ack) begin
                resp_rdata <= '0;
                resp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized + directed bench for mem_lsu against an arithmetic big-endian memory model.
module tb_mem_lsu;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-3:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_ack;

    always #5 clk = ~clk;

    mem_lsu #(.AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Behavioural word memory; unwritten words read back a fixed hash of their address.
    logic [31:0] mem [int unsigned];

    function automatic logic [31:0] rd(input int unsigned wa);
        if (mem.exists(wa)) return mem[wa];
        return (wa * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    int          rd_delay, wr_delay, wait_cnt, xfers;
    bit          in_xfer, noise;
    logic [29:0] xa, last_wa;
    logic        xwe;
    logic [31:0] xwd;

    // One memory cycle, called right after each falling edge.
    task automatic mem_step();
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (!mem_req) begin
            in_xfer = 0;
            if (noise && $urandom_range(3) == 0) mem_ack = 1'b1;
        end else begin
            if (!in_xfer) begin
                in_xfer  = 1;
                wait_cnt = 0;
                xa  = mem_addr;
                xwe = mem_we;
                xwd = mem_wdata;
            end else begin
                check("hold_addr", 32'(mem_addr), 32'(xa));
                check("hold_we", 32'(mem_we), 32'(xwe));
                check("hold_wdata", mem_wdata, xwd);
            end
            if (wait_cnt >= (xwe ? wr_delay : rd_delay)) begin
                mem_ack = 1'b1;
                xfers++;
                if (xwe) begin
                    mem[int'(xa)] = xwd;
                    last_wa = xa;
                end else begin
                    mem_rdata = rd(int'(xa));
                end
                in_xfer = 0;
            end else begin
                wait_cnt++;
            end
        end
    endtask

    function automatic bit m_legal(input logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd10};
    endfunction

    function automatic bit m_misaligned(input logic [3:0] op, input logic [31:0] a);
        if (op == 4'd0 || op == 4'd8) return (a % 4) != 0;
        if (op inside {4'd1, 4'd2, 4'd9}) return (a % 2) != 0;
        return 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] w);
        int unsigned k = a % 4;
        logic [31:0] b = (w >> (8 * (3 - k))) & 32'hFF;
        logic [31:0] h = (a % 4 >= 2) ? (w & 32'hFFFF) : (w >> 16);
        case (op)
            4'd0: return w;
            4'd1: return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            4'd2: return h;
            4'd3: return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
            4'd4: return b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_store(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] old, input logic [31:0] wd);
        int unsigned sh;
        logic [31:0] mask;
        case (op)
            4'd8: return wd;
            4'd9: begin
                sh   = (a % 4 >= 2) ? 0 : 16;
                mask = 32'hFFFF << sh;
                return (old & ~mask) | ((wd & 32'hFFFF) << sh);
            end
            4'd10: begin
                sh   = 8 * (3 - (a % 4));
                mask = 32'hFF << sh;
                return (old & ~mask) | ((wd & 32'hFF) << sh);
            end
            default: return old;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input int dr, input int dw);
        logic [31:0] old, exp_rd, exp_word;
        bit err, got, any_req;
        int lat, nx;
        old      = rd(addr >> 2);
        err      = !m_legal(op) || m_misaligned(op, addr);
        exp_rd   = 32'h0;
        exp_word = old;
        if (err) begin
            lat = 1; nx = 0;
        end else if (op == 4'd8) begin
            lat = 2 + dw; nx = 1; exp_word = wd;
        end else if (op >= 4'd8) begin
            lat = 3 + dr + dw; nx = 2; exp_word = m_store(op, addr, old, wd);
        end else begin
            lat = 2 + dr; nx = 1; exp_rd = m_load(op, addr, old);
        end
        rd_delay = dr;
        wr_delay = dw;
        xfers    = 0;
        got      = 0;
        any_req  = 0;

        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        mem_step();
        check({tag, "_ready"}, 32'(req_ready), 32'd1);

        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_op    = 4'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
            if (mem_req) any_req = 1;
            mem_step();
            if (resp_valid) begin
                got = 1;
                check({tag, "_lat"}, 32'(c), 32'(lat));
                check({tag, "_err"}, 32'(resp_err), 32'(err));
                check({tag, "_rdata"}, resp_rdata, exp_rd);
            end
        end
        if (!got) check({tag, "_timeout"}, 32'd0, 32'd1);
        if (err) check({tag, "_noreq"}, 32'(any_req), 32'd0);

        @(negedge clk);
        mem_step();
        check({tag, "_pulse"}, 32'(resp_valid), 32'd0);
        check({tag, "_hold"}, resp_rdata, exp_rd);
        check({tag, "_idle"}, 32'(req_ready), 32'd1);
        check({tag, "_xfers"}, 32'(xfers), 32'(nx));
        check({tag, "_word"}, rd(addr >> 2), exp_word);
        if (!err && op >= 4'd8) check({tag, "_waddr"}, 32'(last_wa), addr >> 2);
    endtask

    task automatic reset_abort();
        bit seen = 0;
        mem[32'h80] = 32'h11223344;
        rd_delay = 0;
        wr_delay = 30;
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd9; req_addr = 32'h200; req_wdata = 32'h0000BEEF;
        mem_step();
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            mem_step();
            if (mem_req && mem_we) seen = 1;
        end
        check("abort_wr_seen", 32'(seen), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        mem_step();
        check("abort_req", 32'(mem_req), 32'd0);
        check("abort_resp", 32'(resp_valid), 32'd0);
        check("abort_ready_rst", 32'(req_ready), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_step();
            check("abort_noresp", 32'(resp_valid), 32'd0);
            check("abort_ready", 32'(req_ready), 32'd1);
        end
        run_op("abort_lw", 4'd0, 32'h200, 32'h0, 1, 0);
    endtask

    task automatic back_to_back();
        int resps = 0;
        logic [31:0] a = 32'hCAFEF00D, b = 32'h01234567;
        mem[32'h30] = a;
        mem[32'h31] = b;
        rd_delay = 0;
        noise    = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd0; req_addr = 32'hC0;
        mem_step();
        check("b2b_acc0", 32'(req_ready), 32'd1);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) req_addr = 32'hC4;
            if (c == 4) req_valid = 1'b0;
            mem_step();
            if (resp_valid) resps++;
            case (c)
                1: check("b2b_busy1", 32'(req_ready), 32'd0);
                2: begin
                    check("b2b_resp0", 32'(resp_valid), 32'd1);
                    check("b2b_data0", resp_rdata, a);
                    check("b2b_busy2", 32'(req_ready), 32'd0);
                end
                3: check("b2b_acc1", 32'(req_ready), 32'd1);
                4: check("b2b_addr1", 32'(mem_addr), 32'h31);
                5: begin
                    check("b2b_resp1", 32'(resp_valid), 32'd1);
                    check("b2b_data1", resp_rdata, b);
                end
                default: ;
            endcase
        end
        check("b2b_count", 32'(resps), 32'd2);
    endtask

    initial begin
        logic [3:0] ops [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd10, 4'd7, 4'd15};
        logic [31:0] addr;
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0; noise = 0; in_xfer = 0;
        rd_delay = 0; wr_delay = 0; xfers = 0; last_wa = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);

        mem[32'h10] = 32'h8899AABB;
        run_op("lb_41", 4'd3, 32'h41, 32'h0, 0, 0);
        run_op("lbu_43", 4'd4, 32'h43, 32'h0, 0, 0);
        run_op("lh_40", 4'd1, 32'h40, 32'h0, 0, 0);
        run_op("lhu_42", 4'd2, 32'h42, 32'h0, 0, 0);
        run_op("sb_42", 4'd10, 32'h42, 32'h12345677, 0, 0);
        check("sb_42_value", rd(32'h10), 32'h889977BB);
        run_op("sw_100", 4'd8, 32'h100, 32'hDEADBEEF, 0, 3);
        run_op("lw_mis", 4'd0, 32'h102, 32'h0, 0, 0);
        run_op("sh_mis", 4'd9, 32'h101, 32'hFFFF, 0, 0);
        run_op("op_ill", 4'd7, 32'h44, 32'h0, 0, 0);

        reset_abort();
        back_to_back();

        noise = 1;
        for (int i = 0; i < 250; i++) begin
            addr = 32'h400 + 32'($urandom_range(63));
            if ($urandom_range(1) == 1) addr = addr & ~32'h3;
            run_op("rand", ops[$urandom_range(9)], addr, $urandom,
                   $urandom_range(3), $urandom_range(3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
